// File: rtl/aes_enc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_arb_pkg
// Description : Shared widths and FSM state encoding for the AES-256 encrypt
//               core arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_enc_arb_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational requester picker. Searches upward from ptr with
//               wrap-around and returns a one-hot grant plus its index.
//               AES_ENC_ARB_FIXED_PRIO_EN: ignore ptr, lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] start;
  logic [IDW-1:0] idx;
  logic           found;

`ifdef AES_ENC_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`else
  assign start      = ptr;
`endif

  // First requesting index at or after the start point wins
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(start) + k) % NREQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_arbiter
// Description : Shares one AES-256 Encrypt core between NREQ requesters.
//               Arbitrates, registers operands onto the core, waits the fixed
//               core latency, and returns the result on a tagged response.
//               AES_ENC_ARB_FIXED_PRIO_EN: fixed priority, no pointer register.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_arbiter
  import aes_enc_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int CORE_LAT = 14,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*BLK_W-1:0] req_data,
  input  logic [NREQ*KEY_W-1:0] req_key,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BLK_W-1:0]      resp_data,
  output logic [IDW-1:0]        resp_id,
  output logic [BLK_W-1:0]      core_in,
  output logic [KEY_W-1:0]      core_key,
  input  logic [BLK_W-1:0]      core_out
);

  localparam int               CNT_W    = $clog2(CORE_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [BLK_W-1:0] core_in_q,    core_in_d;
  logic [KEY_W-1:0] core_key_q,   core_key_d;
  logic [BLK_W-1:0] resp_data_q,  resp_data_d;
  logic [IDW-1:0]   resp_id_q,    resp_id_d;
  logic             resp_valid_q, resp_valid_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   arb_ptr;
  logic [BLK_W-1:0] sel_data;
  logic [KEY_W-1:0] sel_key;
  logic             accept;

`ifdef AES_ENC_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (arb_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant is only offered while idle; gnt is already zero with no requests
  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  // Route the granted requester's operands toward the core registers
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_data = req_data[i*BLK_W +: BLK_W];
        sel_key  = req_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Next-state, latency countdown and response capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_in_d    = core_in_q;
    core_key_d   = core_key_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
`ifndef AES_ENC_ARB_FIXED_PRIO_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          core_in_d  = sel_data;
          core_key_d = sel_key;
          resp_id_d  = gnt_id;
          cnt_d      = CNT_LOAD;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          resp_data_d  = core_out;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
`ifndef AES_ENC_ARB_FIXED_PRIO_EN
          ptr_d = (resp_id_q == IDW'(NREQ - 1)) ? '0 : resp_id_q + IDW'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_in_q    <= '0;
      core_key_q   <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
`ifndef AES_ENC_ARB_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_in_q    <= core_in_d;
      core_key_q   <= core_key_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
`ifndef AES_ENC_ARB_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign core_in    = core_in_q;
  assign core_key   = core_key_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_valid = resp_valid_q;

endmodule
`default_nettype wire
